// File: rtl/db_ram_arb.sv
// Two-requester burst arbiter/sequencer for port A of the deblocking-filter line RAM.
// Define DB_RAM_ARB_FIXPRIO_EN for fixed priority (r0 wins ties); default is round-robin.
module db_ram_arb #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [LEN_W-1:0]  r0_len_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_wnext_o,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r0_done_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [LEN_W-1:0]  r1_len_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_wnext_o,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              r1_done_o,
    output logic              ram_cen_o,
    output logic              ram_oen_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;

    logic              state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [1:0]        wnext_q, wnext_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        gnt_c;
    logic              sel_c;
`ifndef DB_RAM_ARB_FIXPRIO_EN
    logic              last_gnt_q, last_gnt_d;
`endif

    // Grant decision is combinational so the descriptor is latched in the grant cycle.
    always_comb begin
        gnt_c = 2'b00;
        if (state_q == S_IDLE) begin
            if (r0_req_i && r1_req_i) begin
`ifdef DB_RAM_ARB_FIXPRIO_EN
                gnt_c = 2'b01;
`else
                gnt_c = last_gnt_q ? 2'b01 : 2'b10;
`endif
            end else begin
                gnt_c = {r1_req_i, r0_req_i};
            end
        end
    end

    assign sel_c = gnt_c[1];

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_cnt_d = addr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        cen_d      = 1'b1;
        wen_d      = 1'b1;
        wnext_d    = 2'b00;
        rvalid_d   = 2'b00;
        done_d     = 2'b00;
`ifndef DB_RAM_ARB_FIXPRIO_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_c != 2'b00) begin
                    owner_d    = sel_c;
                    we_d       = sel_c ? r1_we_i : r0_we_i;
                    addr_cnt_d = sel_c ? r1_addr_i : r0_addr_i;
                    beat_cnt_d = sel_c ? r1_len_i : r0_len_i;
                    state_d    = S_BURST;
                    cen_d      = 1'b0;
                    wen_d      = ~we_d;
                    wnext_d[sel_c] = we_d;
`ifndef DB_RAM_ARB_FIXPRIO_EN
                    last_gnt_d = sel_c;
`endif
                end
            end
            default: begin
                // One access is on the RAM pins this cycle; prepare the next one.
                addr_cnt_d       = ADDR_W'(addr_cnt_q + 1'b1);
                beat_cnt_d       = LEN_W'(beat_cnt_q - 1'b1);
                rvalid_d[owner_q] = ~we_q;
                if (beat_cnt_q == '0) begin
                    state_d         = S_IDLE;
                    done_d[owner_q] = 1'b1;
                end else begin
                    cen_d            = 1'b0;
                    wen_d            = ~we_q;
                    wnext_d[owner_q] = we_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            cen_q      <= 1'b1;
            wen_q      <= 1'b1;
            wnext_q    <= 2'b00;
            rvalid_q   <= 2'b00;
            done_q     <= 2'b00;
`ifndef DB_RAM_ARB_FIXPRIO_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_cnt_q <= addr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            cen_q      <= cen_d;
            wen_q      <= wen_d;
            wnext_q    <= wnext_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
`ifndef DB_RAM_ARB_FIXPRIO_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign r0_gnt_o    = gnt_c[0];
    assign r1_gnt_o    = gnt_c[1];
    assign r0_wnext_o  = wnext_q[0];
    assign r1_wnext_o  = wnext_q[1];
    assign r0_rvalid_o = rvalid_q[0];
    assign r1_rvalid_o = rvalid_q[1];
    assign r0_done_o   = done_q[0];
    assign r1_done_o   = done_q[1];
    assign r0_rdata_o  = ram_data_i;
    assign r1_rdata_o  = ram_data_i;

    assign ram_cen_o  = cen_q;
    assign ram_wen_o  = wen_q;
    assign ram_oen_o  = 1'b0;
    assign ram_addr_o = addr_cnt_q;
    // Write beat passes straight through so the requester can advance right after wnext.
    assign ram_data_o = wnext_q[0] ? r0_wdata_i :
                        wnext_q[1] ? r1_wdata_i : '0;

endmodule

// File: tb/tb_db_ram_arb.sv
// Directed bench for db_ram_arb: RAM model, access/read scoreboards, grant ordering, reset abort.
module tb_db_ram_arb;

    typedef struct packed {
        logic [7:0]   addr;
        logic         wen;
        logic [127:0] data;
    } acc_t;

    typedef struct packed {
        logic         own;
        logic [127:0] data;
    } rd_t;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   we_v;
    logic [7:0]   addr_v [2];
    logic [3:0]   len_v  [2];
    logic [127:0] wdata  [2];
    logic [1:0]   gnt, wnext, rvalid, done;
    logic [127:0] rdata  [2];
    logic         ram_cen, ram_oen, ram_wen;
    logic [7:0]   ram_addr;
    logic [127:0] ram_wd, ram_q;
    logic [127:0] mem   [256];
    logic [127:0] model [256];

    acc_t acc_q [$];
    rd_t  rd_q  [$];
    logic glog  [$];
    acc_t ea;
    rd_t  er;
    int   checks, errors, cyc;
    int   done_cnt [2];
    int   g0, g1;

    db_ram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_i(req[0]), .r0_we_i(we_v[0]), .r0_addr_i(addr_v[0]), .r0_len_i(len_v[0]),
        .r0_wdata_i(wdata[0]), .r0_gnt_o(gnt[0]), .r0_wnext_o(wnext[0]),
        .r0_rvalid_o(rvalid[0]), .r0_rdata_o(rdata[0]), .r0_done_o(done[0]),
        .r1_req_i(req[1]), .r1_we_i(we_v[1]), .r1_addr_i(addr_v[1]), .r1_len_i(len_v[1]),
        .r1_wdata_i(wdata[1]), .r1_gnt_o(gnt[1]), .r1_wnext_o(wnext[1]),
        .r1_rvalid_o(rvalid[1]), .r1_rdata_o(rdata[1]), .r1_done_o(done[1]),
        .ram_cen_o(ram_cen), .ram_oen_o(ram_oen), .ram_wen_o(ram_wen),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wd), .ram_data_i(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: read data appears one cycle after the access.
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_wen) mem[ram_addr] <= ram_wd;
            else          ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int n, input logic we, input logic [7:0] a,
                            input logic [3:0] len, input logic [127:0] base);
        for (int k = 0; k <= int'(len); k++) begin
            logic [7:0] ad;
            ad = a + 8'(k);
            if (we) begin
                acc_q.push_back('{addr: ad, wen: 1'b0, data: base + 128'(k)});
                model[ad] = base + 128'(k);
            end else begin
                acc_q.push_back('{addr: ad, wen: 1'b1, data: 128'd0});
                rd_q.push_back('{own: n[0], data: model[ad]});
            end
        end
    endtask

    task automatic burst(input int n, input logic we, input logic [7:0] a,
                         input logic [3:0] len, input logic [127:0] base, output int gcyc);
        int  k;
        bit  got;
        gcyc = -1;
        @(posedge clk); #1;
        req[n] = 1'b1; we_v[n] = we; addr_v[n] = a; len_v[n] = len; wdata[n] = base;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (gnt[n]) got = 1;
        end
        chk("gnt_seen", 128'(gnt[n]), 128'd1);
        if (!got) return;
        gcyc = cyc;
        push_exp(n, we, a, len, base);
        @(posedge clk); #1;
        req[n] = 1'b0;
        k = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done[n]) got = 1;
            else if (wnext[n]) begin
                k++;
                @(posedge clk); #1;
                wdata[n] = base + 128'(k);
            end
        end
        chk("done_seen", 128'(done[n]), 128'd1);
        chk("done_cycle", 128'(cyc - gcyc), 128'(int'(len) + 2));
    endtask

    // Keeps req asserted across bursts so every done cycle sees both requesters.
    task automatic stream(input int n, input int cnt, input logic [7:0] a0);
        bit got;
        @(posedge clk); #1;
        req[n] = 1'b1; we_v[n] = 1'b0; len_v[n] = 4'd1; addr_v[n] = a0;
        for (int g = 0; g < cnt; g++) begin
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (gnt[n]) got = 1;
            end
            chk("stream_gnt", 128'(gnt[n]), 128'd1);
            if (!got) break;
            push_exp(n, 1'b0, addr_v[n], 4'd1, 128'd0);
            @(posedge clk); #1;
            addr_v[n] = addr_v[n] + 8'd2;
        end
        req[n] = 1'b0;
    endtask

    // Monitor: every RAM access and every read return is checked against the scoreboards.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 2'b00) begin
                chk("gnt_onehot", 128'($countones(gnt)), 128'd1);
                chk("gnt_no_access", 128'(ram_cen), 128'd1);
                glog.push_back(gnt[1]);
            end
            if (!ram_cen) begin
                if (acc_q.size() == 0) chk("acc_unexpected", 128'(ram_cen), 128'd1);
                else begin
                    ea = acc_q.pop_front();
                    chk("acc_addr", 128'(ram_addr), 128'(ea.addr));
                    chk("acc_wen", 128'(ram_wen), 128'(ea.wen));
                    chk("acc_data", ram_wd, ea.data);
                end
            end
            if (rvalid != 2'b00) begin
                chk("rvalid_onehot", 128'($countones(rvalid)), 128'd1);
                if (rd_q.size() == 0) chk("rd_unexpected", 128'(rvalid), 128'd0);
                else begin
                    er = rd_q.pop_front();
                    chk("rd_owner", 128'(rvalid[1]), 128'(er.own));
                    chk("rd_data", rdata[er.own], er.data);
                end
            end
            if (done[0]) done_cnt[0]++;
            if (done[1]) done_cnt[1]++;
        end
    end

    initial begin
        int d0;
        bit got;
        checks = 0; errors = 0; cyc = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        rst_n = 1'b0; req = 2'b00; we_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 8'd0; len_v[i] = 4'd0; wdata[i] = 128'd0;
        end
        for (int i = 0; i < 256; i++) begin
            mem[i]   = {4{32'(i) ^ 32'hA5A5_0000}};
            model[i] = {4{32'(i) ^ 32'hA5A5_0000}};
        end
        ram_q = 128'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cen", 128'(ram_cen), 128'd1);
        chk("rst_wen", 128'(ram_wen), 128'd1);
        chk("rst_oen", 128'(ram_oen), 128'd0);
        chk("rst_addr", 128'(ram_addr), 128'd0);
        chk("rst_data", ram_wd, 128'd0);
        chk("rst_gnt", 128'(gnt), 128'd0);
        chk("rst_rvalid", 128'(rvalid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_wnext", 128'(wnext), 128'd0);
        rst_n = 1'b1;

        // Simultaneous first requests: r0 wins, r1 granted in r0's done cycle
        fork
            burst(0, 1'b1, 8'h20, 4'd1, 128'h5000, g0);
            burst(1, 1'b0, 8'h30, 4'd1, 128'd0, g1);
        join
        chk("tie_r1_after_r0", 128'(g1 - g0), 128'd3);

        // r0 write across the address wrap, then readback by r1
        burst(0, 1'b1, 8'hFE, 4'd3, 128'hD0, g0);
        burst(1, 1'b0, 8'hFE, 4'd3, 128'd0, g1);

        // Single-beat read
        burst(1, 1'b0, 8'h10, 4'd0, 128'd0, g1);

        // Continuous requests from both: round-robin alternation starting with r0
        repeat (2) @(negedge clk);
        glog.delete();
        fork
            stream(0, 3, 8'h40);
            stream(1, 3, 8'h80);
        join
        repeat (6) @(negedge clk);
        chk("alt_count", 128'(glog.size()), 128'd6);
        for (int i = 0; i < glog.size(); i++) chk("alt_order", 128'(glog[i]), 128'(i % 2));

        // Reset during the 3rd beat of a len=7 read
        @(posedge clk); #1;
        req[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'h60; len_v[0] = 4'd7;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (gnt[0]) got = 1;
        end
        chk("abort_gnt", 128'(gnt[0]), 128'd1);
        push_exp(0, 1'b0, 8'h60, 4'd7, 128'd0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        d0 = done_cnt[0];
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_cen", 128'(ram_cen), 128'd0);
        rst_n = 1'b0;
        acc_q.delete();
        rd_q.delete();
        @(negedge clk);
        chk("abort_cen", 128'(ram_cen), 128'd1);
        chk("abort_rvalid", 128'(rvalid), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt[0]), 128'(d0));
        chk("abort_idle_cen", 128'(ram_cen), 128'd1);
        for (int i = 0; i < 256; i++) model[i] = mem[i];

        // Fresh request after reset release
        burst(1, 1'b0, 8'h12, 4'd2, 128'd0, g1);
        repeat (3) @(negedge clk);
        chk("acc_drained", 128'(acc_q.size()), 128'd0);
        chk("rd_drained", 128'(rd_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
